// File: rtl/decode_wb_stage_if.sv
// Execute-stage inputs, combinational execute results and registered M-stage outputs of decode_wb_stage.
interface decode_wb_stage_if;
   logic        [1:0]  E_stat;
   logic        [3:0]  E_icode;
   logic        [3:0]  E_ifun;
   logic signed [63:0] E_valC;
   logic signed [63:0] E_valA;
   logic signed [63:0] E_valB;
   logic        [3:0]  E_dstE;
   logic        [3:0]  E_dstM;
   logic               set_cc;
   logic               M_bubble;

   logic        [63:0] e_valE;
   logic               e_Cnd;
   logic        [3:0]  e_dstE;

   logic        [1:0]  M_stat;
   logic        [3:0]  M_icode;
   logic        [3:0]  M_Cnd;
   logic        [63:0] M_valE;
   logic        [63:0] M_valA;
   logic        [3:0]  M_dstE;
   logic        [3:0]  M_dstM;

   modport master (
      output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, set_cc, M_bubble,
      input  e_valE, e_Cnd, e_dstE,
      input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
   );

   modport slave (
      input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, set_cc, M_bubble,
      output e_valE, e_Cnd, e_dstE,
      output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
   );
endinterface

// File: rtl/decode_wb_stage.sv
// Y86-64 execute stage: combinational ALU/condition results, one-cycle M register, no backpressure (bubble only).
// Overflow flag computed only when DECODE_WB_STAGE_OVF_EN is defined; otherwise OF stays 0.
module decode_wb_stage (
   input  logic              clk,
   input  logic              rst_n,
   decode_wb_stage_if.slave  bus
);
   localparam logic [3:0] I_NOP    = 4'd1;
   localparam logic [3:0] I_RRMOV  = 4'd2;
   localparam logic [3:0] I_IRMOV  = 4'd3;
   localparam logic [3:0] I_RMMOV  = 4'd4;
   localparam logic [3:0] I_MRMOV  = 4'd5;
   localparam logic [3:0] I_OPQ    = 4'd6;
   localparam logic [3:0] I_JXX    = 4'd7;
   localparam logic [3:0] I_CALL   = 4'd8;
   localparam logic [3:0] I_RET    = 4'd9;
   localparam logic [3:0] I_PUSH   = 4'd10;
   localparam logic [3:0] I_POP    = 4'd11;
   localparam logic [3:0] R_NONE   = 4'hF;

   typedef struct packed {
      logic [1:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  cnd;
      logic [63:0] val_e;
      logic [63:0] val_a;
      logic [3:0]  dst_e;
      logic [3:0]  dst_m;
   } m_reg_t;

   localparam m_reg_t M_BUBBLE = '{stat: 2'd0, icode: I_NOP, cnd: 4'd0, val_e: 64'd0,
                                   val_a: 64'd0, dst_e: R_NONE, dst_m: R_NONE};

   logic [63:0] val_a;
   logic [63:0] val_b;
   logic [63:0] val_c;
   logic [63:0] alu_res;
   logic [63:0] val_e;
   logic        ovf;
   logic        zf;
   logic        sf;
   logic        of;
   logic        cnd;
   logic [3:0]  dst_e;
   m_reg_t      m_q;

   assign val_a = bus.E_valA;
   assign val_b = bus.E_valB;
   assign val_c = bus.E_valC;

   always_comb begin
      alu_res = 64'd0;
      case (bus.E_ifun)
         4'd0:    alu_res = val_b + val_a;
         4'd1:    alu_res = val_b - val_a;
         4'd2:    alu_res = val_b & val_a;
         4'd3:    alu_res = val_b ^ val_a;
         default: alu_res = 64'd0;
      endcase
   end

`ifdef DECODE_WB_STAGE_OVF_EN
   always_comb begin
      ovf = 1'b0;
      case (bus.E_ifun)
         4'd0:    ovf = (val_b[63] == val_a[63]) && (alu_res[63] != val_b[63]);
         4'd1:    ovf = (val_b[63] != val_a[63]) && (alu_res[63] != val_b[63]);
         default: ovf = 1'b0;
      endcase
   end
`else
   assign ovf = 1'b0;
`endif

   always_comb begin
      val_e = 64'd0;
      case (bus.E_icode)
         I_RRMOV:          val_e = val_a;
         I_IRMOV:          val_e = val_c;
         I_RMMOV, I_MRMOV: val_e = val_b + val_c;
         I_OPQ:            val_e = alu_res;
         I_CALL, I_PUSH:   val_e = val_b - 64'd8;
         I_RET, I_POP:     val_e = val_b + 64'd8;
         default:          val_e = 64'd0;
      endcase
   end

   // Conditions read only the registered flags, so a flag write shows up one cycle later.
   always_comb begin
      cnd = 1'b0;
      if (bus.E_icode == I_RRMOV || bus.E_icode == I_JXX) begin
         case (bus.E_ifun)
            4'd0:    cnd = 1'b1;
            4'd1:    cnd = (sf ^ of) | zf;
            4'd2:    cnd = sf ^ of;
            4'd3:    cnd = zf;
            4'd4:    cnd = ~zf;
            4'd5:    cnd = ~(sf ^ of);
            4'd6:    cnd = ~(sf ^ of) & ~zf;
            default: cnd = 1'b0;
         endcase
      end
   end

   assign dst_e = (bus.E_icode == I_RRMOV && !cnd) ? R_NONE : bus.E_dstE;

   assign bus.e_valE = val_e;
   assign bus.e_Cnd  = cnd;
   assign bus.e_dstE = dst_e;

   // Flag update ignores M_bubble and E_stat on purpose.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zf <= 1'b1;
         sf <= 1'b0;
         of <= 1'b0;
      end else if (bus.set_cc && bus.E_icode == I_OPQ) begin
         zf <= (alu_res == 64'd0);
         sf <= alu_res[63];
         of <= ovf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q <= M_BUBBLE;
      end else if (bus.M_bubble) begin
         m_q <= M_BUBBLE;
      end else begin
         m_q <= '{stat: bus.E_stat, icode: bus.E_icode, cnd: {3'b000, cnd}, val_e: val_e,
                  val_a: val_a, dst_e: dst_e, dst_m: bus.E_dstM};
      end
   end

   assign bus.M_stat  = m_q.stat;
   assign bus.M_icode = m_q.icode;
   assign bus.M_Cnd   = m_q.cnd;
   assign bus.M_valE  = m_q.val_e;
   assign bus.M_valA  = m_q.val_a;
   assign bus.M_dstE  = m_q.dst_e;
   assign bus.M_dstM  = m_q.dst_m;
endmodule

// File: tb/tb_decode_wb_stage.sv
// Self-checking bench for decode_wb_stage: directed Y86-64 cases plus random ops, M results via a scoreboard queue.
module tb_decode_wb_stage;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   decode_wb_stage_if bus ();

   decode_wb_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  cnd;
      logic [63:0] val_e;
      logic [63:0] val_a;
      logic [3:0]  dst_e;
      logic [3:0]  dst_m;
   } m_exp_t;

   m_exp_t sb[$];
   int errors = 0;
   int checks = 0;

   // reference flags
   logic zf_m, sf_m, of_m;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_op(input logic [3:0] ifun, input logic [63:0] a, input logic [63:0] b);
      if (ifun == 0) return b + a;
      if (ifun == 1) return b - a;
      if (ifun == 2) return b & a;
      if (ifun == 3) return b ^ a;
      return 64'd0;
   endfunction

   function automatic logic [63:0] ref_vale(input logic [3:0] icode, input logic [3:0] ifun,
                                            input logic [63:0] c, input logic [63:0] a, input logic [63:0] b);
      if (icode == 2) return a;
      if (icode == 3) return c;
      if (icode == 4 || icode == 5) return b + c;
      if (icode == 6) return ref_op(ifun, a, b);
      if (icode == 8 || icode == 10) return b - 64'd8;
      if (icode == 9 || icode == 11) return b + 64'd8;
      return 64'd0;
   endfunction

   function automatic logic ref_of(input logic [3:0] ifun, input logic [63:0] a, input logic [63:0] b);
      logic signed [63:0] sa, sb_, sr;
      sa = a; sb_ = b; sr = ref_op(ifun, a, b);
`ifdef DECODE_WB_STAGE_OVF_EN
      if (ifun == 0) return (sa > 0 && sb_ > 0 && sr < 0) || (sa < 0 && sb_ < 0 && sr >= 0);
      if (ifun == 1) return (sb_ >= 0 && sa < 0 && sr < 0) || (sb_ < 0 && sa >= 0 && sr >= 0);
`endif
      return 1'b0;
   endfunction

   function automatic logic ref_cnd(input logic [3:0] icode, input logic [3:0] ifun);
      logic lt;
      lt = sf_m ^ of_m;
      if (icode != 2 && icode != 7) return 1'b0;
      case (ifun)
         0: return 1'b1;
         1: return lt | zf_m;
         2: return lt;
         3: return zf_m;
         4: return !zf_m;
         5: return !lt;
         6: return !lt && !zf_m;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check_m(input string tag, input m_exp_t e);
      check({tag, ".M_stat"},  {62'd0, bus.M_stat},  {62'd0, e.stat});
      check({tag, ".M_icode"}, {60'd0, bus.M_icode}, {60'd0, e.icode});
      check({tag, ".M_Cnd"},   {60'd0, bus.M_Cnd},   {60'd0, e.cnd});
      check({tag, ".M_valE"},  bus.M_valE,           e.val_e);
      check({tag, ".M_valA"},  bus.M_valA,           e.val_a);
      check({tag, ".M_dstE"},  {60'd0, bus.M_dstE},  {60'd0, e.dst_e});
      check({tag, ".M_dstM"},  {60'd0, bus.M_dstM},  {60'd0, e.dst_m});
   endtask

   function automatic m_exp_t bubble_val();
      m_exp_t b;
      b = '{2'd0, 4'd1, 4'd0, 64'd0, 64'd0, 4'hF, 4'hF};
      return b;
   endfunction

   // Drive one E-stage instruction just after a rising edge, check execute results, then M after the edge.
   task automatic step(input string tag, input logic [1:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] c, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] dste, input logic [3:0] dstm, input logic setcc, input logic bub);
      logic [63:0] ve, res;
      logic        cn;
      logic [3:0]  de;
      m_exp_t      e, got;
      bus.E_stat = stat; bus.E_icode = icode; bus.E_ifun = ifun;
      bus.E_valC = c; bus.E_valA = a; bus.E_valB = b;
      bus.E_dstE = dste; bus.E_dstM = dstm;
      bus.set_cc = setcc; bus.M_bubble = bub;
      #1;
      ve = ref_vale(icode, ifun, c, a, b);
      cn = ref_cnd(icode, ifun);
      de = (icode == 2 && !cn) ? 4'hF : dste;
      check({tag, ".e_valE"}, bus.e_valE, ve);
      check({tag, ".e_Cnd"},  {63'd0, bus.e_Cnd},  {63'd0, cn});
      check({tag, ".e_dstE"}, {60'd0, bus.e_dstE}, {60'd0, de});
      if (bub) e = bubble_val();
      else     e = '{stat, icode, {3'b000, cn}, ve, a, de, dstm};
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (setcc && icode == 6) begin
         res  = ref_op(ifun, a, b);
         zf_m = (res == 64'd0);
         sf_m = res[63];
         of_m = ref_of(ifun, a, b);
      end
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty got 0 expected 1 entry", tag);
      end else begin
         got = sb.pop_front();
         check_m(tag, got);
      end
   endtask

   initial begin
      logic [63:0] ra, rb, rc;
      logic [3:0]  ric, rif;
      rst_n = 1'b1;
      bus.E_stat = 2'd2; bus.E_icode = 4'd3; bus.E_ifun = 4'd0;
      bus.E_valC = 64'd77; bus.E_valA = 64'd5; bus.E_valB = 64'd6;
      bus.E_dstE = 4'd1; bus.E_dstM = 4'd2; bus.set_cc = 1'b0; bus.M_bubble = 1'b0;
      zf_m = 1'b1; sf_m = 1'b0; of_m = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      check_m("reset_async", bubble_val());
      @(posedge clk); #2;
      check_m("reset_hold", bubble_val());
      rst_n = 1'b1;

      // ZF=1 after reset: je taken
      step("je_after_reset", 2'd0, 4'd7, 4'd3, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
      step("add_ovf", 2'd0, 4'd6, 4'd0, 64'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'd2, 4'hF, 1'b1, 1'b0);
      step("jl_after_ovf", 2'd0, 4'd7, 4'd2, 64'h80, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
      step("jne_after_ovf", 2'd0, 4'd7, 4'd4, 64'h80, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
      step("cmove_fail", 2'd0, 4'd2, 4'd3, 64'd0, 64'h1234, 64'd0, 4'd3, 4'hF, 1'b0, 1'b0);
      step("sub_zero", 2'd0, 4'd6, 4'd1, 64'd0, 64'd5, 64'd5, 4'd4, 4'hF, 1'b1, 1'b0);
      step("je_taken", 2'd0, 4'd7, 4'd3, 64'h100, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
      step("cmove_ok", 2'd0, 4'd2, 4'd3, 64'd0, 64'h55, 64'd0, 4'd3, 4'hF, 1'b0, 1'b0);
      step("sub_ovf", 2'd0, 4'd6, 4'd1, 64'd0, 64'd1, 64'h8000_0000_0000_0000, 4'd5, 4'hF, 1'b1, 1'b0);
      step("jge_after_subovf", 2'd0, 4'd7, 4'd5, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
      step("push", 2'd0, 4'd10, 4'd0, 64'd0, 64'd9, 64'h100, 4'd4, 4'hF, 1'b0, 1'b0);
      step("pop", 2'd0, 4'd11, 4'd0, 64'd0, 64'd9, 64'h100, 4'd4, 4'd6, 1'b0, 1'b0);
      step("mrmov", 2'd0, 4'd5, 4'd0, 64'd8, 64'd0, 64'h10, 4'hF, 4'd7, 1'b0, 1'b0);
      step("and_flags_bubble", 2'd3, 4'd6, 4'd2, 64'd0, 64'hF0, 64'h0F, 4'd1, 4'hF, 1'b1, 1'b1);
      step("je_after_bubble_and", 2'd0, 4'd7, 4'd3, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
      step("bubble_irmov", 2'd0, 4'd3, 4'd0, 64'h99, 64'd0, 64'd0, 4'd2, 4'hF, 1'b0, 1'b1);
      step("stat_pass", 2'd2, 4'd6, 4'd3, 64'd0, 64'hFF, 64'hFF, 4'd1, 4'hF, 1'b1, 1'b0);
      step("jle", 2'd0, 4'd7, 4'd1, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
      step("jg", 2'd0, 4'd7, 4'd6, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
      step("bad_ifun", 2'd0, 4'd6, 4'd7, 64'd0, 64'd3, 64'd4, 4'd1, 4'hF, 1'b0, 1'b0);

      // mid-operation reset discards M contents and restores ZF=1
      step("pre_reset", 2'd1, 4'd3, 4'd0, 64'hABCD, 64'd1, 64'd2, 4'd8, 4'd9, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      zf_m = 1'b1; sf_m = 1'b0; of_m = 1'b0;
      check_m("mid_reset", bubble_val());
      rst_n = 1'b1;
      @(posedge clk); #1;
      step("je_after_midreset", 2'd0, 4'd7, 4'd3, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         ric = 4'($urandom_range(0, 11));
         rif = 4'($urandom_range(0, 7));
         ra = {$urandom, $urandom};
         rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
         rc = {$urandom, $urandom};
         step($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), ric, rif, rc, ra, rb,
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
